// File: rtl/tse_pcs_cfg_master_if.sv
// Avalon-MM style control-port bus between the PCS configuration master and the TSE PCS.
interface tse_pcs_cfg_master_if;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_wr;
  logic        cfg_rd;
  logic [15:0] cfg_rdata;
  logic        cfg_busy;

  modport master (output cfg_addr, cfg_wdata, cfg_wr, cfg_rd, input cfg_rdata, cfg_busy);
  modport slave  (input cfg_addr, cfg_wdata, cfg_wr, cfg_rd, output cfg_rdata, cfg_busy);
endinterface

// File: rtl/tse_pcs_cfg_master.sv
// Brings up the TSE PCS over its control port after reset or start, then keeps polling link status.
// Define TSE_CFG_SCRATCH_CHECK_EN to prefix the sequence with a scratch register (0x10) readback check.
module tse_pcs_cfg_master #(
  parameter logic [20:0] LINK_TIMER    = 21'd200000,
  parameter logic [15:0] IF_MODE       = 16'h0003,
  parameter logic [15:0] DEV_ABILITY   = 16'h4001,
  parameter logic [15:0] CTRL_INIT     = 16'h9140,
  parameter int          POLL_INTERVAL = 1000,
  parameter int          AN_TIMEOUT    = 2000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  tse_pcs_cfg_master_if.master cfg,
  output logic                 link_up,
  output logic [15:0]          partner_ability,
  output logic                 cfg_error,
  output logic                 cfg_active
);
  localparam int WAIT_W = $clog2(POLL_INTERVAL + 1);
  localparam int TO_W   = $clog2(AN_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] POLL_LAST = WAIT_W'(POLL_INTERVAL - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AN_TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(AN_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, WR_LT_LO, WR_LT_HI, WR_IFM, WR_DEV, WR_CTRL, RD_CTRL, RD_STAT,
    RD_PART, WAIT, MONITOR, ERROR, WR_SCR, RD_SCR
  } state_t;

`ifdef TSE_CFG_SCRATCH_CHECK_EN
  localparam logic [15:0] SCRATCH_PATTERN = 16'hA55A;
  localparam state_t      SEQ_START       = WR_SCR;
`else
  localparam state_t      SEQ_START       = WR_LT_LO;
`endif

  state_t              r_state, w_state, r_retState, w_retState;
  logic                r_wr, w_wr, r_rd, w_rd;
  logic [4:0]          r_addr, w_addr;
  logic [15:0]         r_wdata, w_wdata, r_partner, w_partner;
  logic                r_linkUp, w_linkUp, r_error, w_error, r_active, w_active;
  logic [WAIT_W-1:0]   r_waitCnt, w_waitCnt;
  logic [TO_W-1:0]     r_toCnt, w_toCnt;
  logic                r_toRun, w_toRun;
  logic                w_launch, w_xferDone, w_isBus;

  // Packed {is_read, address, write data} for the access a bus state performs.
  function automatic logic [21:0] accessFor(input state_t s);
    case (s)
`ifdef TSE_CFG_SCRATCH_CHECK_EN
      WR_SCR:   accessFor = {1'b0, 5'h10, SCRATCH_PATTERN};
      RD_SCR:   accessFor = {1'b1, 5'h10, 16'h0000};
`endif
      WR_LT_LO: accessFor = {1'b0, 5'h12, LINK_TIMER[15:1], 1'b0};
      WR_LT_HI: accessFor = {1'b0, 5'h13, 11'b0, LINK_TIMER[20:16]};
      WR_IFM:   accessFor = {1'b0, 5'h14, IF_MODE};
      WR_DEV:   accessFor = {1'b0, 5'h04, DEV_ABILITY};
      WR_CTRL:  accessFor = {1'b0, 5'h00, CTRL_INIT};
      RD_CTRL:  accessFor = {1'b1, 5'h00, 16'h0000};
      RD_STAT:  accessFor = {1'b1, 5'h01, 16'h0000};
      RD_PART:  accessFor = {1'b1, 5'h05, 16'h0000};
      default:  accessFor = 22'h0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= SEQ_START;
      r_retState <= RD_STAT;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_addr     <= 5'h00;
      r_wdata    <= 16'h0000;
      r_partner  <= 16'h0000;
      r_linkUp   <= 1'b0;
      r_error    <= 1'b0;
      r_active   <= 1'b1;
      r_waitCnt  <= '0;
      r_toCnt    <= '0;
      r_toRun    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_retState <= w_retState;
      r_wr       <= w_wr;
      r_rd       <= w_rd;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_partner  <= w_partner;
      r_linkUp   <= w_linkUp;
      r_error    <= w_error;
      r_active   <= w_active;
      r_waitCnt  <= w_waitCnt;
      r_toCnt    <= w_toCnt;
      r_toRun    <= w_toRun;
    end
  end

  // Bus states raise their strobe one cycle after entry; leaving WAIT/MONITOR raises it at once,
  // so exactly POLL_INTERVAL idle cycles separate consecutive polls.
  always_comb begin
    w_state    = r_state;
    w_retState = r_retState;
    w_wr       = r_wr;
    w_rd       = r_rd;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_partner  = r_partner;
    w_linkUp   = r_linkUp;
    w_error    = r_error;
    w_active   = r_active;
    w_waitCnt  = r_waitCnt;
    w_toCnt    = r_toCnt;
    w_toRun    = r_toRun;
    w_launch   = 1'b0;
    w_xferDone = (r_wr | r_rd) & ~cfg.cfg_busy;
    w_isBus    = r_state inside {WR_LT_LO, WR_LT_HI, WR_IFM, WR_DEV, WR_CTRL, RD_CTRL, RD_STAT, RD_PART};
`ifdef TSE_CFG_SCRATCH_CHECK_EN
    if (r_state inside {WR_SCR, RD_SCR}) w_isBus = 1'b1;
`endif

    if (r_toRun && r_active && r_toCnt == TO_LAST) begin
      w_state  = ERROR;
      w_wr     = 1'b0;
      w_rd     = 1'b0;
      w_error  = 1'b1;
      w_active = 1'b0;
      w_toRun  = 1'b0;
    end else begin
      if (r_toRun && r_active && r_toCnt != TO_MAX) w_toCnt = r_toCnt + TO_W'(1);
      if (w_isBus && !(r_wr || r_rd)) w_launch = 1'b1;
      if (w_xferDone) begin
        w_wr = 1'b0;
        w_rd = 1'b0;
      end
      case (r_state)
        IDLE:     w_state = SEQ_START;
`ifdef TSE_CFG_SCRATCH_CHECK_EN
        WR_SCR:   if (w_xferDone) w_state = RD_SCR;
        RD_SCR:   if (w_xferDone) begin
                    if (cfg.cfg_rdata != SCRATCH_PATTERN) begin
                      w_state  = ERROR;
                      w_error  = 1'b1;
                      w_active = 1'b0;
                    end else begin
                      w_state = WR_LT_LO;
                    end
                  end
`endif
        WR_LT_LO: if (w_xferDone) w_state = WR_LT_HI;
        WR_LT_HI: if (w_xferDone) w_state = WR_IFM;
        WR_IFM:   if (w_xferDone) w_state = WR_DEV;
        WR_DEV:   if (w_xferDone) w_state = WR_CTRL;
        WR_CTRL:  if (w_xferDone) begin
                    w_state = RD_CTRL;
                    w_toCnt = '0;
                    w_toRun = 1'b1;
                  end
        RD_CTRL:  if (w_xferDone) begin
                    w_waitCnt  = '0;
                    w_retState = RD_CTRL;
                    w_state    = cfg.cfg_rdata[15] ? WAIT : RD_STAT;
                  end
        RD_STAT:  if (w_xferDone) begin
                    w_linkUp   = cfg.cfg_rdata[2] & cfg.cfg_rdata[5];
                    w_waitCnt  = '0;
                    w_retState = RD_STAT;
                    if (r_active) w_state = w_linkUp ? RD_PART : WAIT;
                    else          w_state = (w_linkUp && !r_linkUp) ? RD_PART : MONITOR;
                  end
        RD_PART:  if (w_xferDone) begin
                    w_partner = cfg.cfg_rdata;
                    w_active  = 1'b0;
                    w_toRun   = 1'b0;
                    w_waitCnt = '0;
                    w_state   = MONITOR;
                  end
        WAIT:     if (r_waitCnt == POLL_LAST) begin
                    w_state   = r_retState;
                    w_waitCnt = '0;
                    w_launch  = 1'b1;
                  end else begin
                    w_waitCnt = r_waitCnt + WAIT_W'(1);
                  end
        MONITOR, ERROR: begin
                    if (start) begin
                      w_state   = SEQ_START;
                      w_error   = 1'b0;
                      w_linkUp  = 1'b0;
                      w_active  = 1'b1;
                      w_waitCnt = '0;
                      w_toCnt   = '0;
                      w_toRun   = 1'b0;
                    end else if (r_state == MONITOR) begin
                      if (r_waitCnt == POLL_LAST) begin
                        w_state   = RD_STAT;
                        w_waitCnt = '0;
                        w_launch  = 1'b1;
                      end else begin
                        w_waitCnt = r_waitCnt + WAIT_W'(1);
                      end
                    end
                  end
        default:  w_state = IDLE;
      endcase
    end

    if (w_launch) begin
      {w_rd, w_addr, w_wdata} = accessFor(w_state);
      w_wr = ~w_rd;
    end
  end

  assign cfg.cfg_addr    = r_addr;
  assign cfg.cfg_wdata   = r_wdata;
  assign cfg.cfg_wr      = r_wr;
  assign cfg.cfg_rd      = r_rd;
  assign link_up         = r_linkUp;
  assign partner_ability = r_partner;
  assign cfg_error       = r_error;
  assign cfg_active      = r_active;
endmodule
